qpp_interleaver: RTL and testbench

// - Upstream feeder for the two constituent RSC encoders of the turbo encoder.
// - Buffers one K-bit code block, then replays it as two lockstep streams:
//   - nat_bit: natural order, to encoder 1.
//   - int_bit: QPP-interleaved order, to encoder 2.
// - Interleaver law: pi(i) = (F1*i + F2*i^2) mod K.
// - Single buffer: alternates LOAD (fill) and DRAIN (replay); no overlap between them.

---
 rtl/turbo_pkg.sv | 16 +
 rtl/qpp_interleaver_if.sv | 9 +
 rtl/qpp_addr_gen.sv | 37 +++
 rtl/qpp_interleaver.sv | 74 +++++++
 tb/tb_qpp_interleaver.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/turbo_pkg.sv
// turbo_pkg: QPP table constants, state encoding and elaboration-time helpers for the turbo encoder front end.
package turbo_pkg;
  localparam int QPP_K  [4] = '{40, 48, 56, 64};
  localparam int QPP_F1 [4] = '{3, 7, 19, 7};
  localparam int QPP_F2 [4] = '{10, 12, 42, 16};
  typedef enum logic {ST_LOAD = 1'b0, ST_DRAIN = 1'b1} state_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int dbl_mod(input int f2, input int k);
    return (2 * f2) % k;
  endfunction
endpackage

// File: rtl/qpp_interleaver_if.sv
// qpp_interleaver_if: input stream, paired output stream and error flag of the QPP interleaver.
interface qpp_interleaver_if;
  logic in_valid, in_ready, in_bit, in_last;
  logic out_valid, out_ready, nat_bit, int_bit, out_last, err;
  modport master(output in_valid, in_bit, in_last, out_ready,
                 input in_ready, out_valid, nat_bit, int_bit, out_last, err);
  modport slave(input in_valid, in_bit, in_last, out_ready,
                output in_ready, out_valid, nat_bit, int_bit, out_last, err);
endinterface

// File: rtl/qpp_addr_gen.sv
// qpp_addr_gen: multiplier-free QPP address recursion, pi += g and g += 2*F2, both mod K.
module qpp_addr_gen import turbo_pkg::*; #(
  parameter int K  = 40,
  parameter int F1 = 3,
  parameter int F2 = 10
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  init,
  input  logic                  step,
  output logic [clog2(K)-1:0]   pi
);
  localparam int AW = clog2(K);
  localparam logic [AW:0]   KW = (AW+1)'(K);
  localparam logic [AW-1:0] G0 = AW'((F1 + F2) % K);
  localparam logic [AW-1:0] DG = AW'(dbl_mod(F2, K));
  logic [AW-1:0] pi_q, pi_d, g_q, g_d;
  function automatic logic [AW-1:0] add_mod(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [AW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s >= KW ? AW'(s - KW) : AW'(s);
  endfunction
  always_comb begin
    pi_d = init ? '0 : step ? add_mod(pi_q, g_q) : pi_q;
    g_d  = init ? G0 : step ? add_mod(g_q, DG) : g_q;
  end
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pi_q <= '0;
      g_q  <= '0;
    end else begin
      pi_q <= pi_d;
      g_q  <= g_d;
    end
  end
  assign pi = pi_q;
endmodule

// File: rtl/qpp_interleaver.sv
// qpp_interleaver: buffers one K-bit block, then replays it in natural and QPP-interleaved order in lockstep.
module qpp_interleaver import turbo_pkg::*; #(
  parameter int K  = QPP_K[0],
  parameter int F1 = QPP_F1[0],
  parameter int F2 = QPP_F2[0]
) (
  input logic               clk,
  input logic               clr_n,
  qpp_interleaver_if.slave  bus
);
  localparam int AW = clog2(K);
  localparam logic [AW-1:0] LAST = AW'(K - 1);
  localparam logic [AW:0]   KW   = (AW+1)'(K);
  localparam logic [AW:0]   KL   = (AW+1)'(K - 1);
  state_e        state_q, state_d;
  logic [AW-1:0] wr_idx_q, wr_idx_d, pi;
  logic [AW:0]   rd_idx_q, rd_idx_d;
  logic [K-1:0]  mem_q, mem_d;
  logic          out_valid_q, out_valid_d, nat_q, nat_d, int_q, int_d, last_q, last_d, err_q, err_d;
  logic          accept, load, hs_last;
  assign accept  = state_q == ST_LOAD && bus.in_valid;
  assign load    = state_q == ST_DRAIN && (!out_valid_q || bus.out_ready) && rd_idx_q < KW;
  assign hs_last = out_valid_q && bus.out_ready && last_q;
  // Holding init through LOAD guarantees g is seeded before the first drain after reset.
  qpp_addr_gen #(.K(K), .F1(F1), .F2(F2)) u_addr (
    .clk(clk), .clr_n(clr_n), .init(state_q == ST_LOAD || hs_last), .step(load), .pi(pi)
  );
  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    mem_d    = mem_q;
    err_d    = err_q;
    if (accept) begin
      mem_d[wr_idx_q] = bus.in_bit;
      wr_idx_d = wr_idx_q == LAST ? '0 : wr_idx_q + 1'b1;
      state_d  = wr_idx_q == LAST ? ST_DRAIN : ST_LOAD;
      err_d    = err_q | (bus.in_last ^ (wr_idx_q == LAST));
    end
    if (hs_last) state_d = ST_LOAD;
    rd_idx_d    = hs_last ? '0 : load ? rd_idx_q + 1'b1 : rd_idx_q;
    out_valid_d = load | (out_valid_q & !bus.out_ready);
    nat_d       = load ? mem_q[rd_idx_q[AW-1:0]] : nat_q;
    int_d       = load ? mem_q[pi] : int_q;
    last_d      = load ? rd_idx_q == KL : last_q;
  end
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= ST_LOAD;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      out_valid_q <= 1'b0;
      nat_q       <= 1'b0;
      int_q       <= 1'b0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      out_valid_q <= out_valid_d;
      nat_q       <= nat_d;
      int_q       <= int_d;
      last_q      <= last_d;
      err_q       <= err_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  assign bus.in_ready  = state_q == ST_LOAD;
  assign bus.out_valid = out_valid_q;
  assign bus.nat_bit   = nat_q;
  assign bus.int_bit   = int_q;
  assign bus.out_last  = last_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_qpp_interleaver.sv
// tb_qpp_interleaver: randomized scenario bench against a permutation model computed directly from pi(i).
module tb_qpp_interleaver;
  localparam int K = 40, F1 = 3, F2 = 10;
  logic clk = 1'b0, clr_n = 1'b0;
  int errors = 0, checks = 0;
  qpp_interleaver_if bus();
  qpp_interleaver #(.K(K), .F1(F1), .F2(F2)) dut (.clk(clk), .clr_n(clr_n), .bus(bus));
  always #5 clk = ~clk;
  logic [K-1:0] r_nat, r_int;
  int r_beats, r_last_cnt, r_last_beat, r_hold_bad, r_rdy_bad, r_first_ov;
  function automatic logic [K-1:0] model_int(input logic [K-1:0] b);
    logic [K-1:0] r;
    for (int i = 0; i < K; i++) r[i] = b[(F1 * i + F2 * i * i) % K];
    return r;
  endfunction
  function automatic logic [K-1:0] rand_blk();
    return K'({$urandom(), $urandom()});
  endfunction
  task automatic load_block(input logic [K-1:0] b, input int n, input int last_pos, output int waits);
    waits = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_bit   = b[i];
      bus.in_last  = (i == last_pos);
      while (!bus.in_ready && waits < 200) begin
        @(negedge clk);
        waits++;
      end
    end
  endtask
  task automatic drain(input bit bp);
    logic pv;
    logic [3:0] pw, cur;
    int cyc;
    r_nat = '0; r_int = '0; r_beats = 0; r_last_cnt = 0; r_last_beat = -1;
    r_hold_bad = 0; r_rdy_bad = 0; r_first_ov = -1; pv = 1'b0; pw = '0; cyc = 0;
    while (r_beats < K && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      bus.in_valid = 1'b0;
      cur = {bus.out_valid, bus.nat_bit, bus.int_bit, bus.out_last};
      if (bus.in_ready) r_rdy_bad++;
      if (pv && cur !== pw) r_hold_bad++;
      if (bus.out_valid && r_first_ov < 0) r_first_ov = cyc;
      bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      pv = bus.out_valid && !bus.out_ready;
      pw = cur;
      if (bus.out_valid && bus.out_ready) begin
        r_nat[r_beats] = bus.nat_bit;
        r_int[r_beats] = bus.int_bit;
        if (bus.out_last) begin
          r_last_cnt++;
          r_last_beat = r_beats;
        end
        r_beats++;
      end
    end
  endtask
  task automatic test_reset();
    clr_n = 1'b0;
    #12;
    checks++;
    if ({bus.out_valid, bus.nat_bit, bus.int_bit, bus.out_last, bus.err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000", {bus.out_valid, bus.nat_bit, bus.int_bit, bus.out_last, bus.err});
    end
    @(negedge clk) clr_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
  endtask
  task automatic test_impulse(input int p, input int exp_i);
    logic [K-1:0] b, e;
    int w;
    b = '0; b[p] = 1'b1;
    e = '0; e[exp_i] = 1'b1;
    load_block(b, K, K - 1, w);
    drain(1'b0);
    checks++;
    if (r_int !== e || r_nat !== b || r_beats != K) begin
      errors++;
      $display("FAIL impulse_%0d: int=%h nat=%h beats=%0d expected int=%h nat=%h beats=%0d", p, r_int, r_nat, r_beats, e, b, K);
    end
  endtask
  task automatic test_permutation();
    logic [K-1:0] b, hit;
    int w, pos;
    hit = '0;
    for (int p = 0; p < K; p++) begin
      b = '0; b[p] = 1'b1;
      load_block(b, K, K - 1, w);
      drain(1'b0);
      checks++;
      if (r_int !== model_int(b) || $countones(r_int) != 1) begin
        errors++;
        $display("FAIL perm_%0d: got %h expected %h", p, r_int, model_int(b));
      end
      checks++;
      if (r_last_cnt != 1 || r_last_beat != K - 1) begin
        errors++;
        $display("FAIL perm_last_%0d: count=%0d beat=%0d expected 1 at %0d", p, r_last_cnt, r_last_beat, K - 1);
      end
      pos = 0;
      for (int i = 0; i < K; i++) if (r_int[i]) pos = i;
      hit[pos] = 1'b1;
    end
    checks++;
    if ($countones(hit) != K) begin
      errors++;
      $display("FAIL perm_distinct: got %0d distinct positions expected %0d", $countones(hit), K);
    end
  endtask
  task automatic test_random();
    logic [K-1:0] b;
    int w;
    for (int n = 0; n < 4; n++) begin
      b = rand_blk();
      load_block(b, K, K - 1, w);
      drain(1'b0);
      checks++;
      if (r_nat !== b || r_int !== model_int(b) || r_beats != K) begin
        errors++;
        $display("FAIL random_%0d: nat=%h int=%h expected nat=%h int=%h", n, r_nat, r_int, b, model_int(b));
      end
      checks++;
      if (r_first_ov != 2 || r_rdy_bad != 0 || bus.err !== 1'b0) begin
        errors++;
        $display("FAIL random_timing_%0d: first_valid=%0d rdy_in_drain=%0d err=%b expected 2 0 0", n, r_first_ov, r_rdy_bad, bus.err);
      end
    end
  endtask
  task automatic test_backpressure();
    logic [K-1:0] b;
    int w;
    for (int n = 0; n < 3; n++) begin
      b = rand_blk();
      load_block(b, K, K - 1, w);
      drain(1'b1);
      checks++;
      if (r_nat !== b || r_int !== model_int(b)) begin
        errors++;
        $display("FAIL bp_data_%0d: nat=%h int=%h expected nat=%h int=%h", n, r_nat, r_int, b, model_int(b));
      end
      checks++;
      if (r_beats != K || r_hold_bad != 0 || r_rdy_bad != 0 || r_last_cnt != 1 || r_last_beat != K - 1) begin
        errors++;
        $display("FAIL bp_ctrl_%0d: beats=%0d hold_bad=%0d rdy_bad=%0d last=%0d@%0d expected %0d 0 0 1@%0d",
                 n, r_beats, r_hold_bad, r_rdy_bad, r_last_cnt, r_last_beat, K, K - 1);
      end
    end
  endtask
  task automatic test_back_to_back();
    logic [K-1:0] b1, b2;
    int w;
    b1 = rand_blk();
    b2 = rand_blk();
    load_block(b1, K, K - 1, w);
    drain(1'b0);
    load_block(b2, K, K - 1, w);
    checks++;
    if (w != 0) begin
      errors++;
      $display("FAIL b2b_in_ready: got %0d stall cycles expected 0", w);
    end
    drain(1'b0);
    checks++;
    if (r_nat !== b2 || r_int !== model_int(b2) || r_beats != K) begin
      errors++;
      $display("FAIL b2b_data: nat=%h int=%h expected nat=%h int=%h", r_nat, r_int, b2, model_int(b2));
    end
  endtask
  task automatic test_in_last_err();
    logic [K-1:0] b;
    int w;
    b = rand_blk();
    load_block(b, K, 20, w);
    drain(1'b0);
    checks++;
    if (bus.err !== 1'b1 || r_beats != K || r_int !== model_int(b)) begin
      errors++;
      $display("FAIL in_last_err: err=%b beats=%0d int=%h expected err=1 beats=%0d int=%h", bus.err, r_beats, r_int, K, model_int(b));
    end
    b = rand_blk();
    load_block(b, K, K - 1, w);
    drain(1'b0);
    checks++;
    if (bus.err !== 1'b1 || r_nat !== b) begin
      errors++;
      $display("FAIL err_sticky: err=%b nat=%h expected err=1 nat=%h", bus.err, r_nat, b);
    end
  endtask
  task automatic test_reset_mid(input bit in_drain);
    logic [K-1:0] b;
    int w;
    b = rand_blk();
    load_block(b, in_drain ? K : 25, K - 1, w);
    for (int i = 0; i < (in_drain ? 6 : 1); i++) begin
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    clr_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.err !== 1'b0 || bus.out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_%0d: in_ready=%b out_valid=%b err=%b last=%b expected 1 0 0 0",
               in_drain, bus.in_ready, bus.out_valid, bus.err, bus.out_last);
    end
    @(negedge clk) clr_n = 1'b1;
    b = rand_blk();
    load_block(b, K, K - 1, w);
    drain(1'b0);
    checks++;
    if (r_nat !== b || r_int !== model_int(b) || r_beats != K || r_last_beat != K - 1) begin
      errors++;
      $display("FAIL reset_mid_next_%0d: nat=%h int=%h expected nat=%h int=%h", in_drain, r_nat, r_int, b, model_int(b));
    end
  endtask
  initial begin
    bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    test_reset();
    test_impulse(13, 1);
    test_impulse(6, 2);
    test_impulse(0, 0);
    test_impulse(19, 3);
    test_impulse(12, 4);
    test_permutation();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_in_last_err();
    test_reset_mid(1'b0);
    test_reset_mid(1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
